lsu_bus_bridge: RTL

Load/store stage directly downstream of the single-cycle core's ALU address output. It replaces the core's combinational RAM access with a valid/ready request and response bus to data memory or peripherals. It also does byte-lane steering, load sign/zero extension, misalignment and timeout detection, and stalls the core until each access completes.

---
 rtl/lsu_bus_bridge.sv | 114 +++++++++++
 1 files changed

// File: rtl/lsu_bus_bridge.sv
// lsu_bus_bridge: load/store bridge from the core's ALU address to a valid/ready memory bus, with lane steering, load extension and fault detection
module lsu_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_mode,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_fault,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic              bus_req_we,
  output logic [3:0]        bus_req_wstrb,
  output logic [31:0]       bus_req_wdata,
  input  logic              bus_rsp_valid,
  input  logic [31:0]       bus_rsp_data,
  input  logic              bus_rsp_err
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} stateT;
  stateT state, nextState;
  logic [CNT_W-1:0] cnt;
  logic [1:0] offsetQ;
  logic [3:0] modeQ;
  logic isLoad, isStore, isHalf, isWord, badReq, timeUp;
  logic [3:0] wstrbD;
  logic [31:0] wdataD, loadVal;
  logic [7:0] rByte;
  logic [15:0] rHalf;
  assign isLoad = cpu_mode inside {[4'd1:4'd5]};
  assign isStore = cpu_mode inside {[4'd9:4'd11]};
  assign isHalf = cpu_mode inside {4'd2, 4'd5, 4'd10};
  assign isWord = cpu_mode inside {4'd3, 4'd11};
  assign badReq = (!isLoad && !isStore) || (isHalf && cpu_addr[0]) || (isWord && cpu_addr[1:0] != 2'd0);
  assign wstrbD = cpu_mode == 4'd9 ? 4'b0001 << cpu_addr[1:0] :
                  cpu_mode == 4'd10 ? 4'b0011 << cpu_addr[1:0] :
                  cpu_mode == 4'd11 ? 4'b1111 : 4'b0000;
  assign wdataD = cpu_mode == 4'd9 ? {4{cpu_wdata[7:0]}} :
                  cpu_mode == 4'd10 ? {2{cpu_wdata[15:0]}} :
                  cpu_mode == 4'd11 ? cpu_wdata : 32'd0;
  assign rByte = bus_rsp_data[{offsetQ, 3'b000} +: 8];
  assign rHalf = offsetQ[1] ? bus_rsp_data[31:16] : bus_rsp_data[15:0];
  assign loadVal = modeQ == 4'd1 ? {{24{rByte[7]}}, rByte} :
                   modeQ == 4'd2 ? {{16{rHalf[15]}}, rHalf} :
                   modeQ == 4'd3 ? bus_rsp_data :
                   modeQ == 4'd4 ? {24'd0, rByte} :
                   modeQ == 4'd5 ? {16'd0, rHalf} : 32'd0;
  // Fires one cycle early so DONE lands exactly TIMEOUT_CYCLES edges after the count starts
  assign timeUp = cnt >= CNT_W'(TIMEOUT_CYCLES - 1);
  // Stall is gated by reset so an abandoned access releases the core immediately
  assign cpu_stall = rst_n && (state == REQ || state == WAIT || (state == IDLE && cpu_mode != 4'd0));
  always_comb begin
    nextState = state;
    case (state)
      IDLE: nextState = cpu_mode == 4'd0 ? IDLE : badReq ? DONE : REQ;
      REQ: nextState = bus_req_ready ? WAIT : timeUp ? DONE : REQ;
      WAIT: nextState = (bus_rsp_valid || timeUp) ? DONE : WAIT;
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      offsetQ <= 2'd0;
      modeQ <= 4'd0;
      cpu_rdata <= 32'd0;
      cpu_fault <= 1'b0;
      bus_req_valid <= 1'b0;
      bus_req_addr <= '0;
      bus_req_we <= 1'b0;
      bus_req_wstrb <= 4'd0;
      bus_req_wdata <= 32'd0;
    end else begin
      state <= nextState;
      cpu_fault <= 1'b0;
      cnt <= (state == IDLE || state == DONE || (state == REQ && bus_req_ready)) ? '0 :
             cnt < CNT_W'(TIMEOUT_CYCLES) ? cnt + 1'b1 : cnt;
      case (state)
        IDLE: if (cpu_mode != 4'd0) begin
          if (badReq) cpu_fault <= 1'b1;
          else begin
            bus_req_valid <= 1'b1;
            bus_req_addr <= {cpu_addr[ADDR_W-1:2], 2'b00};
            bus_req_we <= isStore;
            bus_req_wstrb <= wstrbD;
            bus_req_wdata <= wdataD;
            offsetQ <= cpu_addr[1:0];
            modeQ <= cpu_mode;
          end
        end
        REQ: if (bus_req_ready) bus_req_valid <= 1'b0;
        else if (timeUp) begin
          bus_req_valid <= 1'b0;
          cpu_fault <= 1'b1;
          cpu_rdata <= 32'd0;
        end
        WAIT: if (bus_rsp_valid) begin
          cpu_fault <= bus_rsp_err;
          cpu_rdata <= bus_rsp_err ? 32'd0 : loadVal;
        end else if (timeUp) begin
          cpu_fault <= 1'b1;
          cpu_rdata <= 32'd0;
        end
        default: ;
      endcase
    end
  end
endmodule
